// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding and default command/halt values (CHECK only with LOADER_CHECKSUM_EN)
package mips_pkg;
    localparam logic [7:0]  START_CMD_DEF = 8'h01;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        DONE
`ifdef LOADER_CHECKSUM_EN
        ,
        CHECK
`endif
    } state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: MSB-first byte shift register with a per-word byte index
module byte_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             load,
    input  logic             clr,
    input  logic [7:0]       din,
    output logic [WIDTH-1:0] data,
    output logic             last
);
    localparam int N  = WIDTH / 8;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    logic [IW-1:0] idx;
    assign last = idx == IW'(N - 1);
    // shift each byte in at the bottom so the first byte of a word ends at the top
    always_ff @(posedge clka) begin
        if (rsta) begin
            data <= '0;
            idx  <= '0;
        end else begin
            if (load) data <= (data << 8) | WIDTH'(din);
            if (clr || (load && last)) idx <= '0;
            else if (load) idx <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: byte-stream instruction RAM loader; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and chk_err
module instr_loader
    import mips_pkg::*;
#(
    parameter int                   RAM_WIDTH = 32,
    parameter int                   RAM_DEPTH = 2048,
    parameter logic [7:0]           START_CMD = START_CMD_DEF,
    parameter logic [RAM_WIDTH-1:0] HALT_WORD = RAM_WIDTH'(HALT_WORD_DEF)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [RAM_WIDTH-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0] ram_wdata,
    output logic                 ram_we,
    output logic                 cpu_en,
    output logic                 load_done,
    output logic                 overflow,
    output logic [RAM_WIDTH-1:0] word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                 chk_err
`endif
);
    localparam logic [RAM_WIDTH-1:0] LAST_ADDR = RAM_WIDTH'(RAM_DEPTH - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t HALT_NEXT = CHECK;
    logic [7:0] xsum, xsum_d;
`else
    localparam state_t HALT_NEXT = DONE;
`endif
    state_t state, state_d;
    logic fire, load, clr, last, ovf_d, err_d;
    logic [RAM_WIDTH-1:0] addr_d, count_d;

    byte_packer #(.WIDTH(RAM_WIDTH)) u_packer (
        .clka (clka),
        .rsta (rsta),
        .load (load),
        .clr  (clr),
        .din  (rx_data),
        .data (ram_wdata),
        .last (last)
    );

    // next state, counters and flags; registered outputs are derived from these next values
    always_comb begin
        fire = rx_valid && rx_ready;
        state_d = state;
        addr_d = ram_addr;
        count_d = word_count;
        ovf_d = overflow;
        load = 1'b0;
        clr = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xsum_d = xsum;
        err_d = chk_err;
`else
        err_d = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (fire && rx_data == START_CMD) begin
                    state_d = ASSEMBLE;
                    addr_d = '0;
                    count_d = '0;
                    ovf_d = 1'b0;
                    clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xsum_d = '0;
                    err_d = 1'b0;
`endif
                end
            end
            ASSEMBLE: begin
                if (fire) begin
                    load = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xsum_d = xsum ^ rx_data;
`endif
                    if (last) state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d = ram_addr + 1'b1;
                count_d = word_count + 1'b1;
                clr = 1'b1;
                if (ram_wdata == HALT_WORD) state_d = HALT_NEXT;
                else if (ram_addr == LAST_ADDR) begin
                    ovf_d = 1'b1;
                    state_d = DONE;
                end else state_d = ASSEMBLE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (fire) begin
                    err_d = rx_data != xsum;
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clka) begin
        if (rsta) begin
            state <= IDLE;
            ram_addr <= '0;
            word_count <= '0;
            overflow <= 1'b0;
            load_done <= 1'b0;
            rx_ready <= 1'b0;
            ram_we <= 1'b0;
            cpu_en <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xsum <= '0;
            chk_err <= 1'b0;
`endif
        end else begin
            state <= state_d;
            ram_addr <= addr_d;
            word_count <= count_d;
            overflow <= ovf_d;
            load_done <= state_d == DONE;
            rx_ready <= state_d != WRITE;
            ram_we <= state_d == WRITE;
            cpu_en <= state_d == DONE && !ovf_d && !err_d;
`ifdef LOADER_CHECKSUM_EN
            xsum <= xsum_d;
            chk_err <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader; the checksum scenario is built when LOADER_CHECKSUM_EN is defined
module tb_instr_loader;
    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, ram_we, cpu_en, load_done, overflow;
    logic [31:0] ram_addr, ram_wdata, word_count;
`ifdef LOADER_CHECKSUM_EN
    logic        chk_err;
`endif
    int tests = 0;
    int fails = 0;
    int bp_viol = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    instr_loader #(.RAM_DEPTH(4)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .cpu_en     (cpu_en),
        .load_done  (load_done),
        .overflow   (overflow),
        .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    always #5 clka = ~clka;

    // record every RAM write, and any write cycle where a byte could still be accepted
    always @(negedge clka) begin
        if (ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
            if (rx_ready) bp_viol++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (rx_ready) begin
                @(negedge clka);
                return;
            end
            @(negedge clka);
        end
        tests++;
        fails++;
        $display("FAIL send_byte timeout: rx_ready got 0 for 20 cycles, required 1 (byte %h)", b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic finish_load(input logic [7:0] x);
`ifdef LOADER_CHECKSUM_EN
        send_byte(x);
`else
        rx_data = x;
`endif
        rx_valid = 1'b0;
        repeat (2) @(negedge clka);
    endtask

    task automatic pulse_reset;
        rx_valid = 1'b0;
        rsta = 1'b1;
        @(negedge clka);
        rsta = 1'b0;
    endtask

    task automatic test_reset;
        rsta = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clka);
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset rx_ready got %b exp 0", rx_ready); end
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset ram_we got %b exp 0", ram_we); end
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL reset cpu_en got %b exp 0", cpu_en); end
        tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset load_done got %b exp 0", load_done); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset overflow got %b exp 0", overflow); end
        tests++; if (ram_addr !== 32'd0) begin fails++; $display("FAIL reset ram_addr got %h exp 0", ram_addr); end
        tests++; if (word_count !== 32'd0) begin fails++; $display("FAIL reset word_count got %h exp 0", word_count); end
        tests++; if (ram_wdata !== 32'd0) begin fails++; $display("FAIL reset ram_wdata got %h exp 0", ram_wdata); end
        rsta = 1'b0;
        @(negedge clka);
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_release rx_ready got %b exp 1", rx_ready); end
    endtask

    task automatic test_basic;
        wa.delete();
        wd.delete();
        send_byte(8'h01);
        send_word(32'h2008_0005);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h2D);
        tests++; if (wa.size() !== 2) begin fails++; $display("FAIL basic nwrites got %0d exp 2", wa.size()); end
        tests++; if (wa[0] !== 32'd0 || wd[0] !== 32'h2008_0005) begin fails++; $display("FAIL basic write0 got %h@%h exp 20080005@0", wd[0], wa[0]); end
        tests++; if (wa[1] !== 32'd1 || wd[1] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL basic write1 got %h@%h exp ffffffff@1", wd[1], wa[1]); end
        tests++; if (word_count !== 32'd2) begin fails++; $display("FAIL basic word_count got %0d exp 2", word_count); end
        tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL basic load_done got %b exp 1", load_done); end
        tests++; if (cpu_en !== 1'b1) begin fails++; $display("FAIL basic cpu_en got %b exp 1", cpu_en); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic overflow got %b exp 0", overflow); end
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL basic ram_we_done got %b exp 0", ram_we); end
    endtask

    task automatic test_back_to_back;
        bp_viol = 0;
        send_byte(8'h01);
        wa.delete();
        wd.delete();
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h88);
        tests++; if (wa.size() !== 3) begin fails++; $display("FAIL b2b nwrites got %0d exp 3", wa.size()); end
        tests++; if (wd[0] !== 32'h1122_3344) begin fails++; $display("FAIL b2b word0 got %h exp 11223344", wd[0]); end
        tests++; if (wd[1] !== 32'h5566_7788 || wa[1] !== 32'd1) begin fails++; $display("FAIL b2b word1 got %h@%h exp 55667788@1", wd[1], wa[1]); end
        tests++; if (wd[2] !== 32'hFFFF_FFFF || wa[2] !== 32'd2) begin fails++; $display("FAIL b2b word2 got %h@%h exp ffffffff@2", wd[2], wa[2]); end
        tests++; if (bp_viol !== 0) begin fails++; $display("FAIL b2b ready_in_write got %0d cycles exp 0", bp_viol); end
        tests++; if (word_count !== 32'd3) begin fails++; $display("FAIL b2b word_count got %0d exp 3", word_count); end
    endtask

    task automatic test_overflow;
        send_byte(8'h01);
        wa.delete();
        wd.delete();
        send_word(32'h0A0B_0C0D);
        send_word(32'h1020_3040);
        send_word(32'h5060_7080);
        send_word(32'h90A0_B0C0);
        send_word(32'hD0E0_F0AA);
        rx_valid = 1'b0;
        repeat (2) @(negedge clka);
        tests++; if (wa.size() !== 4) begin fails++; $display("FAIL ovf nwrites got %0d exp 4", wa.size()); end
        tests++; if (wd[0] !== 32'h0A0B_0C0D || wa[0] !== 32'd0) begin fails++; $display("FAIL ovf write0 got %h@%h exp 0a0b0c0d@0", wd[0], wa[0]); end
        tests++; if (wd[3] !== 32'h90A0_B0C0 || wa[3] !== 32'd3) begin fails++; $display("FAIL ovf write3 got %h@%h exp 90a0b0c0@3", wd[3], wa[3]); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf overflow got %b exp 1", overflow); end
        tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL ovf load_done got %b exp 1", load_done); end
        tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL ovf cpu_en got %b exp 0", cpu_en); end
        tests++; if (word_count !== 32'd4) begin fails++; $display("FAIL ovf word_count got %0d exp 4", word_count); end
    endtask

    task automatic test_reset_mid_word;
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_reset();
        tests++; if (rx_ready !== 1'b0 || ram_addr !== 32'd0) begin fails++; $display("FAIL midreset state got ready=%b addr=%h exp ready=0 addr=0", rx_ready, ram_addr); end
        wa.delete();
        wd.delete();
        send_byte(8'h01);
        send_word(32'hAABB_CCDD);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h00);
        tests++; if (wa.size() !== 2) begin fails++; $display("FAIL midreset nwrites got %0d exp 2", wa.size()); end
        tests++; if (wd[0] !== 32'hAABB_CCDD || wa[0] !== 32'd0) begin fails++; $display("FAIL midreset write0 got %h@%h exp aabbccdd@0", wd[0], wa[0]); end
        tests++; if (cpu_en !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL midreset flags got cpu_en=%b ovf=%b exp 1 0", cpu_en, overflow); end
    endtask

    task automatic test_garbage_restart;
        pulse_reset();
        wa.delete();
        wd.delete();
        send_byte(8'h55);
        send_byte(8'h66);
        rx_valid = 1'b0;
        @(negedge clka);
        tests++; if (load_done !== 1'b0 || cpu_en !== 1'b0 || rx_ready !== 1'b1) begin fails++; $display("FAIL garbage idle got done=%b cpu=%b ready=%b exp 0 0 1", load_done, cpu_en, rx_ready); end
        tests++; if (wa.size() !== 0) begin fails++; $display("FAIL garbage nwrites got %0d exp 0", wa.size()); end
        send_byte(8'h01);
        send_word(32'h0000_0007);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h07);
        tests++; if (wd[0] !== 32'h0000_0007 || cpu_en !== 1'b1) begin fails++; $display("FAIL garbage load got %h cpu=%b exp 00000007 1", wd[0], cpu_en); end
        send_byte(8'h77);
        rx_valid = 1'b0;
        @(negedge clka);
        tests++; if (cpu_en !== 1'b1 || load_done !== 1'b1) begin fails++; $display("FAIL garbage done got cpu=%b done=%b exp 1 1", cpu_en, load_done); end
        send_byte(8'h01);
        rx_valid = 1'b0;
        tests++; if (cpu_en !== 1'b0 || load_done !== 1'b0 || word_count !== 32'd0) begin fails++; $display("FAIL restart drop got cpu=%b done=%b cnt=%0d exp 0 0 0", cpu_en, load_done, word_count); end
        wa.delete();
        wd.delete();
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h08);
        tests++; if (wa[0] !== 32'd0 || wd[0] !== 32'h1234_5678) begin fails++; $display("FAIL restart write0 got %h@%h exp 12345678@0", wd[0], wa[0]); end
        tests++; if (word_count !== 32'd2 || cpu_en !== 1'b1) begin fails++; $display("FAIL restart end got cnt=%0d cpu=%b exp 2 1", word_count, cpu_en); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        send_byte(8'h01);
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h01);
        tests++; if (chk_err !== 1'b0 || cpu_en !== 1'b1) begin fails++; $display("FAIL chk_good got err=%b cpu=%b exp 0 1", chk_err, cpu_en); end
        send_byte(8'h01);
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        finish_load(8'h02);
        tests++; if (chk_err !== 1'b1 || cpu_en !== 1'b0 || load_done !== 1'b1) begin fails++; $display("FAIL chk_bad got err=%b cpu=%b done=%b exp 1 0 1", chk_err, cpu_en, load_done); end
        send_byte(8'h01);
        rx_valid = 1'b0;
        tests++; if (chk_err !== 1'b0) begin fails++; $display("FAIL chk_clear got %b exp 0", chk_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_reset_mid_word();
        test_garbage_restart();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
